rename_stage: RTL

- Superscalar register-rename stage. Each cycle it takes up to WIDTH in-order 24-bit micro-ops and allocates physical destinations from a free list.
- It maps sources through a speculative RAT, tracks per-physical-register ready bits, and assigns ROB indices.
- It holds a committed (retirement) RAT so that a flush restores precise state in one cycle.
- It sits between the micro-op queue and the ROB/reservation stations.

---
 rtl/rename_stage_pkg.sv | 42 ++++
 rtl/rename_stage_if.sv | 32 +++
 rtl/rename_stage_slot.sv | 50 +++++
 rtl/rename_stage.sv | 88 ++++++++
 4 files changed

// File: rtl/rename_stage_pkg.sv
// rename_stage_pkg: shared sizes, renamed-uop layout and rename helper functions
package rename_stage_pkg;
    localparam int WIDTH = 4;
    localparam int ARCH_REGS = 10;
    localparam int PHYS_REGS = 32;
    localparam int PR_ADDR_W = 5;
    localparam int ROB_ADDR_W = 5;
    localparam int CMPLT_PORTS = 6;
    localparam int UOP_SZ = 24;
    // renamed uop: {op, pdst0, pdst1, psrc0, psrc1, rdy1, rdy0, imm, rob_idx}
    localparam int RENAMED_OP_SZ = 4 + 4 * PR_ADDR_W + 2 + 4 + ROB_ADDR_W;
    typedef logic [PR_ADDR_W-1:0] preg_t;
    typedef logic [PHYS_REGS-1:0] pmask_t;
    typedef preg_t [15:0] rat_t;

    function automatic logic [1:0] num_dst(input logic [3:0] op);
        return op == 4'b1100 ? 2'd1 : op[3:2] == 2'b11 ? 2'd0 : 2'd2;
    endfunction

    function automatic logic renamed(input logic [3:0] id);
        return id >= 4'd2 && id <= 4'(ARCH_REGS + 1);
    endfunction

    // ids above the renamed range read phys 0, which is permanently ready
    function automatic rat_t reset_rat();
        rat_t r;
        for (int i = 0; i < 16; i++) r[i] = i <= ARCH_REGS + 1 ? preg_t'(i) : '0;
        return r;
    endfunction

    function automatic preg_t lowest(input pmask_t m);
        preg_t p = '0;
        for (int i = PHYS_REGS - 1; i >= 0; i--) if (m[i]) p = preg_t'(i);
        return p;
    endfunction

    function automatic pmask_t unmapped(input rat_t r);
        pmask_t m = ~pmask_t'(3);
        for (int i = 2; i <= ARCH_REGS + 1; i++) m[r[i]] = 1'b0;
        return m;
    endfunction
endpackage

// File: rtl/rename_stage_if.sv
// rename_stage_if: uop queue, ROB, completion and commit signals around the rename stage
interface rename_stage_if;
    import rename_stage_pkg::*;
    logic flush;
    logic [WIDTH*UOP_SZ-1:0] in_uops;
    logic [WIDTH-1:0] in_valid;
    logic [WIDTH-1:0] in_accept;
    logic [ROB_ADDR_W-1:0] rob_tail;
    logic [ROB_ADDR_W:0] rob_free;
    logic [CMPLT_PORTS-1:0] cmplt_valid;
    logic [CMPLT_PORTS*PR_ADDR_W-1:0] cmplt_preg;
    logic [WIDTH-1:0] commit_valid;
    logic [WIDTH*4-1:0] commit_arch;
    logic [WIDTH*PR_ADDR_W-1:0] commit_preg;
    logic [WIDTH*PR_ADDR_W-1:0] commit_old_preg;
    logic [WIDTH*RENAMED_OP_SZ-1:0] out_uops;
    // per slot: old dst0 mapping in the low half, old dst1 in the high half
    logic [WIDTH*2*PR_ADDR_W-1:0] out_old;
    logic [WIDTH-1:0] out_valid;
    logic out_ready;

    modport master(
        output flush, in_uops, in_valid, rob_tail, rob_free, cmplt_valid, cmplt_preg,
               commit_valid, commit_arch, commit_preg, commit_old_preg, out_ready,
        input  in_accept, out_uops, out_old, out_valid
    );
    modport slave(
        input  flush, in_uops, in_valid, rob_tail, rob_free, cmplt_valid, cmplt_preg,
               commit_valid, commit_arch, commit_preg, commit_old_preg, out_ready,
        output in_accept, out_uops, out_old, out_valid
    );
endinterface

// File: rtl/rename_stage_slot.sv
// rename_slot: renames one uop against the free list/RAT/ready state left by earlier slots
module rename_slot
    import rename_stage_pkg::*;
(
    input  logic [UOP_SZ-1:0] uop,
    input  logic en,
    input  logic [ROB_ADDR_W-1:0] rob_idx,
    input  pmask_t free_in,
    input  pmask_t rdy_in,
    input  rat_t rat_in,
    output logic acc,
    output logic [RENAMED_OP_SZ-1:0] ren,
    output logic [2*PR_ADDR_W-1:0] old,
    output pmask_t free_out,
    output pmask_t rdy_out,
    output rat_t rat_out
);
    logic [3:0] op, d0, d1, s0, s1;
    logic [1:0] nd;
    logic n0, n1;
    preg_t p0, p1, ps0, ps1;
    pmask_t a0, a1, f1;
    rat_t r1, r2;

    assign {op, d0, d1, s0, s1} = uop[23:4];
    assign nd = num_dst(op);
    assign n0 = nd != 2'd0 && renamed(d0);
    assign n1 = nd == 2'd2 && renamed(d1);
    assign ps0 = rat_in[s0];
    assign ps1 = rat_in[s1];

    // dst0 takes the lowest free reg, dst1 the next; sources see only earlier slots' writes
    always_comb begin
        p0 = n0 ? lowest(free_in) : '0;
        a0 = n0 ? pmask_t'(1) << p0 : '0;
        f1 = free_in & ~a0;
        p1 = n1 ? lowest(f1) : '0;
        a1 = n1 ? pmask_t'(1) << p1 : '0;
        r1 = rat_in;
        if (n0) r1[d0] = p0;
        r2 = r1;
        if (n1) r2[d1] = p1;
        acc = en && (!n0 || |free_in) && (!n1 || |f1);
        ren = {op, p0, p1, ps0, ps1, rdy_in[ps1], rdy_in[ps0], uop[3:0], rob_idx};
        old = {n1 ? r1[d1] : preg_t'(0), n0 ? rat_in[d0] : preg_t'(0)};
        free_out = acc ? f1 & ~a1 : free_in;
        rdy_out = acc ? rdy_in & ~a0 & ~a1 : rdy_in;
        rat_out = acc ? r2 : rat_in;
    end
endmodule

// File: rtl/rename_stage.sv
// rename_stage: WIDTH-wide register rename with speculative and committed RATs and one-cycle flush recovery
module rename_stage
    import rename_stage_pkg::*;
(
    input logic clk,
    input logic rst_n,
    rename_stage_if.slave bus
);
    rat_t spec_rat, cmt_rat, cmt_next;
    pmask_t free_list, ready, cmplt_mask, old_mask;
    pmask_t free_c [WIDTH+1];
    pmask_t rdy_c [WIDTH+1];
    rat_t rat_c [WIDTH+1];
    logic [WIDTH:0] ok;
    logic [WIDTH-1:0] acc, out_valid;
    logic [WIDTH*RENAMED_OP_SZ-1:0] ren, out_uops;
    logic [WIDTH*2*PR_ADDR_W-1:0] old, out_old;

    assign ok[0] = (!(|out_valid) || bus.out_ready) && !bus.flush;
    assign free_c[0] = free_list;
    assign rdy_c[0] = ready | cmplt_mask;
    assign rat_c[0] = spec_rat;
    assign bus.in_accept = acc;
    assign bus.out_valid = out_valid;
    assign bus.out_uops = out_uops;
    assign bus.out_old = out_old;

    for (genvar k = 0; k < WIDTH; k++) begin : g_slot
        rename_slot u_slot (
            .uop(bus.in_uops[k*UOP_SZ +: UOP_SZ]),
            .en(ok[k] && bus.in_valid[k] && (ROB_ADDR_W+1)'(k) < bus.rob_free),
            .rob_idx(bus.rob_tail + ROB_ADDR_W'(k)),
            .free_in(free_c[k]),
            .rdy_in(rdy_c[k]),
            .rat_in(rat_c[k]),
            .acc(acc[k]),
            .ren(ren[k*RENAMED_OP_SZ +: RENAMED_OP_SZ]),
            .old(old[k*2*PR_ADDR_W +: 2*PR_ADDR_W]),
            .free_out(free_c[k+1]),
            .rdy_out(rdy_c[k+1]),
            .rat_out(rat_c[k+1])
        );
        assign ok[k+1] = acc[k];
    end

    // completion bypass mask, in-order commit into the retirement RAT and regs released by it
    always_comb begin
        cmplt_mask = '0;
        for (int i = 0; i < CMPLT_PORTS; i++)
            if (bus.cmplt_valid[i]) cmplt_mask[bus.cmplt_preg[i*PR_ADDR_W +: PR_ADDR_W]] = 1'b1;
        cmt_next = cmt_rat;
        old_mask = '0;
        for (int i = 0; i < WIDTH; i++)
            if (bus.commit_valid[i] && renamed(bus.commit_arch[i*4 +: 4])) begin
                cmt_next[bus.commit_arch[i*4 +: 4]] = bus.commit_preg[i*PR_ADDR_W +: PR_ADDR_W];
                old_mask[bus.commit_old_preg[i*PR_ADDR_W +: PR_ADDR_W]] = 1'b1;
            end
    end

    // rename state update; flush rebuilds speculative state from the post-commit retirement RAT
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= '0;
            out_uops <= '0;
            out_old <= '0;
            spec_rat <= reset_rat();
            cmt_rat <= reset_rat();
            free_list <= unmapped(reset_rat());
            ready <= '1;
        end else begin
            cmt_rat <= cmt_next;
            if (bus.flush) begin
                out_valid <= '0;
                spec_rat <= cmt_next;
                free_list <= unmapped(cmt_next);
                ready <= '1;
            end else begin
                spec_rat <= rat_c[WIDTH];
                free_list <= free_c[WIDTH] | old_mask;
                ready <= rdy_c[WIDTH];
                if (ok[0]) begin
                    out_valid <= acc;
                    out_uops <= ren;
                    out_old <= old;
                end
            end
        end
endmodule
